// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Optional parity-corruption feature is enabled by ROUTER_TX_ERR_INJ_EN.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } tx_state_t;

   localparam int ADDR_W = 2;
   localparam int LEN_W = 6;
   localparam int MAX_LEN = 63;
   localparam int BUF_DEPTH = MAX_LEN + 1;
   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload buffer: one synchronous write port, one synchronous read port.
module router_tx_buf
   import router_pkg::*;
(
   input  logic               clk,
   input  logic               wr_en,
   input  logic [LEN_W-1:0]   wr_addr,
   input  logic [7:0]         wr_data,
   input  logic               rd_en,
   input  logic [LEN_W-1:0]   rd_addr,
   output logic [7:0]         rd_data
);

   logic [7:0] mem [BUF_DEPTH];

   // NOTE: the memory and its read register have no reset; contents must survive resetn.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-side packet transmitter: header, buffered payload, XOR parity, gap.
// Define ROUTER_TX_ERR_INJ_EN to add the err_inj port that inverts the parity byte.
module router_pkt_tx
   import router_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               wr_en,
   input  logic [LEN_W-1:0]   wr_addr,
   input  logic [7:0]         wr_data,
   input  logic               start,
   input  logic [ADDR_W-1:0]  dest_addr,
   input  logic [LEN_W-1:0]   pl_len,
`ifdef ROUTER_TX_ERR_INJ_EN
   input  logic               err_inj,
`endif
   input  logic               busy,
   output logic               pkt_valid,
   output logic [7:0]         data_out,
   output logic               tx_busy,
   output logic               tx_done,
   output logic               start_err
);

   tx_state_t          state_q, state_n;
   logic [7:0]         data_q, data_n;
   logic               valid_q, valid_n;
   logic [7:0]         acc_q, acc_n;
   logic [LEN_W-1:0]   rem_q, rem_n;
   logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_n;
   logic               start_err_q, start_err_n;
   logic               rd_en;
   logic [LEN_W-1:0]   rd_addr;
   logic [7:0]         rd_data;
   logic [7:0]         par_mask;
   logic [7:0]         hdr_byte;
   logic [7:0]         acc_pl;
   logic               consume;

`ifdef ROUTER_TX_ERR_INJ_EN
   logic inj_q;

   always_ff @(posedge clk) begin
      if (!resetn)
         inj_q <= 1'b0;
      else if (state_q == ST_IDLE && start && dest_addr != ADDR_ILLEGAL)
         inj_q <= err_inj;
   end

   assign par_mask = {8{inj_q}};
`else
   assign par_mask = 8'h00;
`endif

   assign consume  = !busy;
   assign hdr_byte = {pl_len, dest_addr};
   assign acc_pl   = acc_q ^ data_q;

   router_tx_buf u_buf (
      .clk     (clk),
      .wr_en   (wr_en && (state_q == ST_IDLE)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // NOTE: state and datapath registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         acc_q       <= 8'h00;
         rem_q       <= '0;
         rd_ptr_q    <= '0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         data_q      <= data_n;
         valid_q     <= valid_n;
         acc_q       <= acc_n;
         rem_q       <= rem_n;
         rd_ptr_q    <= rd_ptr_n;
         start_err_q <= start_err_n;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_n     = state_q;
      data_n      = data_q;
      valid_n     = valid_q;
      acc_n       = acc_q;
      rem_n       = rem_q;
      rd_ptr_n    = rd_ptr_q;
      start_err_n = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = rd_ptr_q + 6'd1;

      case (state_q)
         ST_IDLE: begin
            // Keep buf[0] prefetched so the first payload byte follows the header directly.
            rd_en    = 1'b1;
            rd_addr  = '0;
            rd_ptr_n = '0;
            if (start) begin
               if (dest_addr == ADDR_ILLEGAL) begin
                  start_err_n = 1'b1;
               end else begin
                  state_n = ST_HEADER;
                  data_n  = hdr_byte;
                  valid_n = 1'b1;
                  acc_n   = hdr_byte;
                  rem_n   = pl_len;
               end
            end
         end
         ST_HEADER: begin
            if (consume) begin
               if (rem_q == '0) begin
                  state_n = ST_PARITY;
                  data_n  = acc_q ^ par_mask;
                  valid_n = 1'b0;
               end else begin
                  state_n  = ST_PAYLOAD;
                  data_n   = rd_data;
                  rd_en    = 1'b1;
                  rd_ptr_n = rd_ptr_q + 6'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (consume) begin
               acc_n = acc_pl;
               if (rem_q == 6'd1) begin
                  state_n = ST_PARITY;
                  data_n  = acc_pl ^ par_mask;
                  valid_n = 1'b0;
               end else begin
                  data_n   = rd_data;
                  rd_en    = 1'b1;
                  rd_ptr_n = rd_ptr_q + 6'd1;
                  rem_n    = rem_q - 6'd1;
               end
            end
         end
         ST_PARITY: begin
            if (consume)
               state_n = ST_GAP;
         end
         ST_GAP: begin
            state_n = ST_IDLE;
            data_n  = 8'h00;
         end
         default: begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            data_n  = 8'h00;
         end
      endcase
   end

   assign pkt_valid = valid_q;
   assign data_out  = data_q;
   assign tx_busy   = (state_q != ST_IDLE);
   assign tx_done   = (state_q == ST_GAP);
   assign start_err = start_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected wire bytes queued at start, popped on consumption.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [5:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic [1:0] dest_addr = '0;
   logic [5:0] pl_len = '0;
   logic       err_inj = 1'b0;
   logic       busy = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_busy;
   logic       tx_done;
   logic       start_err;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;
   logic [7:0] mdl_buf[64];
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;

   router_pkt_tx dut (
      .clk       (clk),
      .resetn    (resetn),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .dest_addr (dest_addr),
      .pl_len    (pl_len),
`ifdef ROUTER_TX_ERR_INJ_EN
      .err_inj   (err_inj),
`endif
      .busy      (busy),
      .pkt_valid (pkt_valid),
      .data_out  (data_out),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .start_err (start_err)
   );

   // A wire byte is consumed at the next rising edge when busy is low.
   always @(negedge clk) begin
      if (mon_en && resetn && tx_busy && !tx_done && !busy) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wire_byte: got valid=%0b data=%02h, required no byte", pkt_valid, data_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({pkt_valid, data_out} !== mon_exp) begin
               n_fail++;
               $display("FAIL wire_byte: got valid=%0b data=%02h, required valid=%0b data=%02h",
                        pkt_valid, data_out, mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en = 1'b0;
      mdl_buf[a] = d;
   endtask

   task automatic launch(input logic [1:0] dst, input logic [5:0] len, input logic inj);
      logic [7:0] acc;
      acc = {len, dst};
      exp_q.push_back({1'b1, acc});
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back({1'b1, mdl_buf[i]});
         acc = acc ^ mdl_buf[i];
      end
      if (inj)
         acc = ~acc;
      exp_q.push_back({1'b0, acc});
      start     = 1'b1;
      dest_addr = dst;
      pl_len    = len;
      err_inj   = inj;
      step();
      start   = 1'b0;
      err_inj = 1'b0;
      n_tests++;
      if (tx_busy !== 1'b1 || pkt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: got tx_busy=%0b valid=%0b, required 1 1", tx_busy, pkt_valid);
      end
   endtask

   task automatic wait_done(input int exp_cycles);
      int cycles;
      cycles = 0;
      while (!tx_done && cycles < 500) begin
         step();
         cycles++;
      end
      n_tests++;
      if (tx_done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: got tx_done=%0b after %0d cycles, required 1", tx_done, cycles);
      end else if (exp_cycles >= 0 && cycles != exp_cycles) begin
         n_fail++;
         $display("FAIL throughput: got %0d cycles to done, required %0d", cycles, exp_cycles);
      end
      step();
      n_tests++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got tx_done=%0b tx_busy=%0b, required 0 0", tx_done, tx_busy);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bytes_missing: got %0d unsent bytes, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_tests++;
      if ({pkt_valid, data_out, tx_busy, tx_done, start_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b data=%02h tx_busy=%0b tx_done=%0b start_err=%0b, required all 0",
                  name, pkt_valid, data_out, tx_busy, tx_done, start_err);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      step();
      step();
      check_idle_outputs("reset_values");
      resetn = 1'b1;
      step();
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      wr_byte(6'd0, 8'h11);
      wr_byte(6'd1, 8'h22);
      wr_byte(6'd2, 8'h33);
      launch(2'd1, 6'd3, 1'b0);
      wait_done(5);
   endtask

   task automatic test_back_to_back_len0();
      launch(2'd2, 6'd0, 1'b0);
      wait_done(2);
   endtask

   task automatic test_stall();
      int guard;
      launch(2'd1, 6'd3, 1'b0);
      guard = 0;
      while (!(pkt_valid && data_out == 8'h22) && guard < 20) begin
         step();
         guard++;
      end
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (pkt_valid !== 1'b1 || data_out !== 8'h22) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=22", pkt_valid, data_out);
         end
      end
      busy = 1'b0;
      wait_done(-1);
   endtask

   task automatic test_start_err();
      start     = 1'b1;
      dest_addr = 2'd3;
      pl_len    = 6'd4;
      step();
      start = 1'b0;
      n_tests++;
      if (start_err !== 1'b1 || tx_busy !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL start_err_pulse: got start_err=%0b tx_busy=%0b valid=%0b data=%02h, required 1 0 0 00",
                  start_err, tx_busy, pkt_valid, data_out);
      end
      step();
      check_idle_outputs("start_err_clear");
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 63; i++)
         wr_byte(6'(i), 8'(i));
      launch(2'd0, 6'd63, 1'b0);
      n_tests++;
      if (exp_q[$] !== 9'h0C3) begin
         n_fail++;
         $display("FAIL max_parity_model: got %03h, required 0C3", exp_q[$]);
      end
      wait_done(65);
`ifdef ROUTER_TX_ERR_INJ_EN
      launch(2'd0, 6'd63, 1'b1);
      n_tests++;
      if (exp_q[$] !== 9'h03C) begin
         n_fail++;
         $display("FAIL inj_parity_model: got %03h, required 03C", exp_q[$]);
      end
      wait_done(65);
`endif
   endtask

   task automatic test_reset_mid();
      int guard;
      mon_en    = 1'b0;
      start     = 1'b1;
      dest_addr = 2'd0;
      pl_len    = 6'd5;
      step();
      start = 1'b0;
      guard = 0;
      while (!(pkt_valid && data_out == 8'h01) && guard < 20) begin
         step();
         guard++;
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_idle_outputs("reset_mid_packet");
      step();
      mon_en = 1'b1;
      launch(2'd0, 6'd5, 1'b0);
      wait_done(7);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back_len0();
      test_stall();
      test_start_err();
      test_max_len();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the router input port. Software or an upstream engine loads payload bytes into an internal 64-byte buffer, then issues `start` with a destination address and length. The block then emits header, payload and parity bytes on the router's byte interface, honouring the router's `busy` back-pressure. It is the source-side counterpart of the router's receive/parity-check path and produces framing that checker accepts with `err` = 0.

## Interface
- `MAX_LEN`, 63: maximum payload bytes. Fixed by the 6-bit length field.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `wr_en` in 1: payload buffer write strobe.
- `wr_addr` in 6: payload buffer write index.
- `wr_data` in 8: payload byte.
- `start` in 1: begin packet, sampled in IDLE only.
- `dest_addr` in 2: destination port, 0..2 legal.
- `pl_len` in 6: payload length, 0..63.
- `err_inj` in 1: corrupt parity. Present only with the macro described under Configuration.
- `busy` in 1: router back-pressure. While high, the presented byte is not consumed.
- `pkt_valid` out 1: high on header and payload bytes, low on the parity byte.
- `data_out` out 8: byte to the router.
- `tx_busy` out 1: high from `start` acceptance through GAP.
- `tx_done` out 1: one-cycle pulse when the packet completes.
- `start_err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- **IDLE**
  - `start`=1 with `dest_addr`≠3: latch the address and length, move to HEADER.
  - `start`=1 with `dest_addr`=3: pulse `start_err`, stay in IDLE.
- **HEADER**
  - `data_out` = {pl_len, dest_addr}, `pkt_valid`=1.
  - Parity accumulator initialised to the header byte.
- **Consumption rule:** a byte is consumed on a rising edge where `busy`=0. Outputs and state advance only on consumption. Otherwise everything holds.
- **HEADER → PAYLOAD:** on consumption. If `pl_len`=0, go directly to PARITY.
- **PAYLOAD**
  - Presents `buf[0..pl_len-1]` in order, `pkt_valid`=1.
  - Each consumed byte XORs into the accumulator.
  - After the last byte is consumed, move to PARITY.
- **PARITY**
  - `data_out` = accumulator (XOR of header and all payload bytes), `pkt_valid`=0.
  - On consumption, move to GAP.
- **GAP**
  - One cycle, `pkt_valid`=0, `data_out` holds the parity byte, `tx_done`=1.
  - Then IDLE.
- **Buffer writes**
  - `wr_en` while `tx_busy`=0: writes `buf[wr_addr]`.
  - `wr_en` while `tx_busy`=1: ignored.
  - Contents persist across packets and across reset.
- `start` outside IDLE is ignored, with no `start_err`.
- Buffer read is synchronous and prefetched one byte ahead, so there are no bubbles between payload bytes.

## Timing
- **Reset values:** `pkt_valid`=0, `data_out`=8'h00, `tx_busy`=0, `tx_done`=0, `start_err`=0, state IDLE, accumulator 0.
- **Start latency:** `start` accepted at edge E0 → header and `pkt_valid` are visible after E0. `tx_busy` rises at the same time.
- **Throughput:** with `busy`=0 throughout, the packet occupies `pl_len`+2 consecutive cycles on the wire, plus one GAP cycle. The next `start` is accepted in the cycle after GAP.
- **`busy` during parity byte:** parity is held with `pkt_valid`=0 until consumed.
- **Reset mid-packet:** `resetn`=0 at any edge aborts the packet, and all outputs go to their reset values the next cycle.
- `start` and `wr_en` in the same IDLE cycle: the write completes, but the transmitted data reflects the prefetch read. Software must not do this; the outcome is defined as using pre-write data.

## Configuration
- `ROUTER_TX_ERR_INJ_EN` defined:
  - The `err_inj` port exists and is sampled with `start`.
  - If set, the parity byte is sent bit-inverted, to exercise the router's `err` path.
- Undefined: the `err_inj` port is absent and parity is always correct.

## Structure
- **`router_pkg`:** state enum, `ADDR_W`=2, `LEN_W`=6, `MAX_LEN`=63, `ADDR_ILLEGAL`=2'b11.
- **Sub-module `router_tx_buf`:** 64x8 memory with a synchronous write port and a synchronous read port.
- Control FSM, length counter and parity accumulator stay in `router_pkt_tx`.

## Test plan
- Load 0x11,0x22,0x33; start addr 1, len 3, busy=0 → bytes 0x0D,0x11,0x22,0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0; `tx_done` pulses one cycle later.
- Start addr 2, len 0 → header 0x02 (`pkt_valid`=1), then parity 0x02 (`pkt_valid`=0).
- Same packet as the first case, `busy` high 3 cycles while 0x22 is presented → `data_out` holds 0x22 with `pkt_valid`=1 for 4 cycles; the rest of the sequence is unchanged.
- Start addr 3 → `start_err` pulses one cycle; `pkt_valid`, `tx_busy` and `data_out` stay 0.
- Buffer 0..62, addr 0, len 63 → header 0xFC, 63 payload bytes, parity 0xC3. With `ROUTER_TX_ERR_INJ_EN` and `err_inj`=1, parity is 0x3C instead.
- `resetn` low for one cycle during the second payload byte → next cycle all outputs 0, state IDLE. A new start then resends from `buf[0]` with the original buffer contents.
